alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_arbiter_rr_arb2.sv | 51 +++++
 rtl/alu_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared widths, one-hot ALU opcode bit positions, the response
//            slot state encoding and a one-hot test helper for alu_arbiter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALUOP_W = 12;
  localparam int DATA_W  = 32;

  // Bit index of each operation inside the one-hot aluop vector.
  localparam int ADD  = 11;
  localparam int SUB  = 10;
  localparam int SLT  = 9;
  localparam int SLTU = 8;
  localparam int AND  = 7;
  localparam int NOR  = 6;
  localparam int OR   = 5;
  localparam int XOR  = 4;
  localparam int SLL  = 3;
  localparam int SRL  = 2;
  localparam int SRA  = 1;
  localparam int LUI  = 0;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_HOLD  = 1'b1
  } slot_state_t;

  // True when exactly one bit is set: non-zero and clearing the lowest set
  // bit leaves nothing behind.
  function automatic logic is_onehot(input logic [ALUOP_W-1:0] op);
    logic [ALUOP_W-1:0] one;
    one = {{(ALUOP_W-1){1'b0}}, 1'b1};
    return (op != '0) && ((op & (op - one)) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way arbiter with a last-grant pointer (round-robin) or a
//            fixed priority to requester 0 when FIXED_PRIO != 0.
// Ports    : clk, resetn      - clock / async active-low reset
//            enable           - grant permitted this cycle (slot free)
//            req[1:0]         - valid requesters
//            grant[1:0]       - one-hot grant (a grant is always accepted)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // Index of the requester granted most recently. Resets to 1 so that
  // requester 0 wins the first conflict.
  logic last;

  always_comb begin
    grant = 2'b00;
    if (enable && resetn) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ((FIXED_PRIO != 0) || last) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Every grant is accepted (ready == grant and the requester is valid),
  // so the pointer follows the grant directly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last <= 1'b1;
    end else if (grant[0]) begin
      last <= 1'b0;
    end else if (grant[1]) begin
      last <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one external combinational ALU between two requesters.
//            A single response slot holds the result for one cycle or more
//            until the owning response port drains it; drain and refill may
//            happen in the same cycle for one op per cycle throughput.
// Ports    : clk, resetn                       - clock / async active-low reset
//            reqN_valid/ready/aluop/src1/src2  - request channels, N = 0,1
//            alu_aluop/alu_in_1/alu_in_2       - operands to the shared ALU
//            alu_result                        - ALU result, same cycle
//            rspN_valid/ready/result/err       - response channels, N = 0,1
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic               clk,
  input  logic               resetn,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [ALUOP_W-1:0] req0_aluop,
  input  logic [DATA_W-1:0]  req0_src1,
  input  logic [DATA_W-1:0]  req0_src2,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [ALUOP_W-1:0] req1_aluop,
  input  logic [DATA_W-1:0]  req1_src1,
  input  logic [DATA_W-1:0]  req1_src2,

  output logic [ALUOP_W-1:0] alu_aluop,
  output logic [DATA_W-1:0]  alu_in_1,
  output logic [DATA_W-1:0]  alu_in_2,
  input  logic [DATA_W-1:0]  alu_result,

  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [DATA_W-1:0]  rsp0_result,
  output logic               rsp0_err,

  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [DATA_W-1:0]  rsp1_result,
  output logic               rsp1_err
);

  slot_state_t       state_q, state_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;

  logic              full;
  logic              drain;
  logic              slot_free;
  logic [1:0]        grant;
  logic              any_grant;
  logic              op_err;

  assign full      = (state_q == SLOT_HOLD);
  assign drain     = full && (owner_q ? rsp1_ready : rsp0_ready);
  // The slot can take a new op if empty, or if the held result leaves
  // on this same edge.
  assign slot_free = !full || drain;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk    (clk),
    .resetn (resetn),
    .enable (slot_free),
    .req    ({req1_valid, req0_valid}),
    .grant  (grant)
  );

  assign any_grant  = grant[0] || grant[1];
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Operand mux: the granted requester drives the ALU, otherwise all zero.
  always_comb begin
    alu_aluop = '0;
    alu_in_1  = '0;
    alu_in_2  = '0;
    if (grant[0]) begin
      alu_aluop = req0_aluop;
      alu_in_1  = req0_src1;
      alu_in_2  = req0_src2;
    end else if (grant[1]) begin
      alu_aluop = req1_aluop;
      alu_in_1  = req1_src1;
      alu_in_2  = req1_src2;
    end
  end

  assign op_err = !is_onehot(alu_aluop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= SLOT_EMPTY;
      owner_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    result_d = result_q;
    err_d    = err_q;
    if (any_grant) begin
      // New load; covers both EMPTY->HOLD and drain-and-refill.
      state_d  = SLOT_HOLD;
      owner_d  = grant[1];
      result_d = op_err ? '0 : alu_result;
      err_d    = op_err;
    end else if (drain) begin
      state_d  = SLOT_EMPTY;
    end
  end

  assign rsp0_valid  = full && !owner_q;
  assign rsp1_valid  = full &&  owner_q;
  assign rsp0_result = rsp0_valid ? result_q : '0;
  assign rsp1_result = rsp1_valid ? result_q : '0;
  assign rsp0_err    = rsp0_valid && err_q;
  assign rsp1_err    = rsp1_valid && err_q;

endmodule
`default_nettype wire
